alu_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares the single combinational ALU between two requesters: port 0 is the pipeline execute stage, port 1 is the auxiliary requester (multi-cycle/debug helper). It accepts one operation at a time with a valid/ready handshake and drives the ALU operand/opcode inputs from registers. It captures the ALU result and returns it to the winning requester through a valid/ready response channel. The block sits between the requesters and the ALU; the ALU itself is unchanged.

---
 rtl/alu_arbiter.sv | 116 +++++++++++
 tb/tb_alu_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port valid/ready arbiter and sequencer for one shared ALU.
// Define ALU_ARB_RR_EN for round-robin arbitration (default: port 0 priority).
module alu_arbiter #(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req0_valid,
   output logic                     req0_ready,
   input  logic [DATA_WIDTH-1:0]    req0_src_a,
   input  logic [DATA_WIDTH-1:0]    req0_src_b,
   input  logic [OPCODE_LENGTH-1:0] req0_op,
   input  logic                     req1_valid,
   output logic                     req1_ready,
   input  logic [DATA_WIDTH-1:0]    req1_src_a,
   input  logic [DATA_WIDTH-1:0]    req1_src_b,
   input  logic [OPCODE_LENGTH-1:0] req1_op,
   output logic                     rsp0_valid,
   input  logic                     rsp0_ready,
   output logic                     rsp1_valid,
   input  logic                     rsp1_ready,
   output logic [DATA_WIDTH-1:0]    rsp_result,
   output logic [DATA_WIDTH-1:0]    alu_src_a,
   output logic [DATA_WIDTH-1:0]    alu_src_b,
   output logic [OPCODE_LENGTH-1:0] alu_operation,
   input  logic [DATA_WIDTH-1:0]    alu_result,
   output logic                     busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                   r_state;
   state_t                   w_next;
   logic                     r_grant;
   logic [DATA_WIDTH-1:0]    r_src_a;
   logic [DATA_WIDTH-1:0]    r_src_b;
   logic [OPCODE_LENGTH-1:0] r_op;
   logic [DATA_WIDTH-1:0]    r_result;
   logic                     w_pick1;
   logic                     w_acc0;
   logic                     w_acc1;
   logic                     w_accept;
   logic                     w_rsp_hs;

`ifdef ALU_ARB_RR_EN
   logic r_last;

   // On contention, grant the port that was not served last.
   always_comb begin
      if (req0_valid && req1_valid) w_pick1 = ~r_last;
      else                          w_pick1 = req1_valid;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_last <= 1'b1;
      else if (w_accept) r_last <= w_pick1;
   end
`else
   assign w_pick1 = req1_valid & ~req0_valid;
`endif

   assign w_acc0   = (r_state == IDLE) & req0_valid & ~w_pick1;
   assign w_acc1   = (r_state == IDLE) & req1_valid & w_pick1;
   assign w_accept = w_acc0 | w_acc1;
   assign w_rsp_hs = (r_state == RESP) &
                     (r_grant ? rsp1_ready : rsp0_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (w_accept) w_next = EXEC;
         EXEC:    w_next = RESP;
         RESP:    if (w_rsp_hs) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_grant  <= 1'b0;
         r_src_a  <= '0;
         r_src_b  <= '0;
         r_op     <= '0;
         r_result <= '0;
      end else begin
         if (w_accept) begin
            r_grant <= w_pick1;
            r_src_a <= w_pick1 ? req1_src_a : req0_src_a;
            r_src_b <= w_pick1 ? req1_src_b : req0_src_b;
            r_op    <= w_pick1 ? req1_op    : req0_op;
         end
         if (r_state == EXEC) r_result <= alu_result;
      end
   end

   assign req0_ready    = w_acc0;
   assign req1_ready    = w_acc1;
   assign rsp0_valid    = (r_state == RESP) & ~r_grant;
   assign rsp1_valid    = (r_state == RESP) & r_grant;
   assign rsp_result    = r_result;
   assign alu_src_a     = r_src_a;
   assign alu_src_b     = r_src_b;
   assign alu_operation = r_op;
   assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter
// against a transaction-level model with a behavioural ALU.
module tb_alu_arbiter;
   localparam int DW = 32;
   localparam int OW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req0_valid, req1_valid, req0_ready, req1_ready;
   logic [DW-1:0] req0_src_a, req0_src_b, req1_src_a, req1_src_b;
   logic [OW-1:0] req0_op, req1_op;
   logic          rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
   logic [DW-1:0] rsp_result, alu_src_a, alu_src_b, alu_result;
   logic [OW-1:0] alu_operation;
   logic          busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b,
                                            input logic [OW-1:0] op);
      case (op)
         4'b0000: return a & b;
         4'b0001: return a - b;
         4'b0010: return a + b;
         4'b0011: return a | b;
         4'b0100: return a ^ b;
         default: return a;
      endcase
   endfunction

   assign alu_result = alu_fn(alu_src_a, alu_src_b, alu_operation);

   alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_src_a(req0_src_a), .req0_src_b(req0_src_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_src_a(req1_src_a), .req1_src_b(req1_src_b), .req1_op(req1_op),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_result(rsp_result),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_operation(alu_operation), .alu_result(alu_result),
      .busy(busy)
   );

   task automatic idle_inputs();
      req0_valid = 0; req1_valid = 0;
      req0_src_a = 0; req0_src_b = 0; req0_op = 0;
      req1_src_a = 0; req1_src_b = 0; req1_op = 0;
      rsp0_ready = 0; rsp1_ready = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      @(negedge clk); rst_n = 0;
      @(negedge clk);
      @(negedge clk); rst_n = 1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      @(negedge clk); #1;
      checks++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctl got %b want 00000",
                  {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy});
      end
      checks++;
      if ({alu_src_a, alu_src_b, alu_operation, rsp_result} !== '0) begin
         errors++;
         $display("FAIL reset_data a=%h b=%h op=%h r=%h want 0",
                  alu_src_a, alu_src_b, alu_operation, rsp_result);
      end
      @(negedge clk); rst_n = 1;
   endtask

   task automatic test_add_port0();
      @(negedge clk);
      req0_valid = 1; req0_src_a = 5; req0_src_b = 7; req0_op = 4'b0010;
      rsp0_ready = 1;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         errors++; $display("FAIL add_accept got %b want 10", {req0_ready, req1_ready});
      end
      @(negedge clk); req0_valid = 0; #1;
      checks++;
      if ({busy, rsp0_valid, rsp1_valid} !== 3'b100) begin
         errors++; $display("FAIL add_exec got %b want 100", {busy, rsp0_valid, rsp1_valid});
      end
      @(negedge clk); #1;
      checks++;
      if ({busy, rsp0_valid, rsp1_valid} !== 3'b110) begin
         errors++; $display("FAIL add_resp got %b want 110", {busy, rsp0_valid, rsp1_valid});
      end
      checks++;
      if (rsp_result !== 32'd12) begin
         errors++; $display("FAIL add_result got %h want 0000000c", rsp_result);
      end
      @(negedge clk); rsp0_ready = 0; #1;
      checks++;
      if ({busy, rsp0_valid} !== 2'b00) begin
         errors++; $display("FAIL add_done got %b want 00", {busy, rsp0_valid});
      end
   endtask

   task automatic test_sub_port1();
      @(negedge clk);
      req1_valid = 1; req1_src_a = 3; req1_src_b = 5; req1_op = 4'b0001;
      rsp1_ready = 1;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         errors++; $display("FAIL sub_accept got %b want 01", {req0_ready, req1_ready});
      end
      @(negedge clk); req1_valid = 0;
      @(negedge clk); #1;
      checks++;
      if ({rsp0_valid, rsp1_valid} !== 2'b01 || rsp_result !== 32'hFFFF_FFFE) begin
         errors++;
         $display("FAIL sub_resp v=%b r=%h want 01 fffffffe",
                  {rsp0_valid, rsp1_valid}, rsp_result);
      end
      @(negedge clk); rsp1_ready = 0;
   endtask

   task automatic test_back_to_back();
      int n;
      int cyc;
      int g[6];
      int t[6];
      do_reset();
      req0_valid = 1; req0_src_a = 10; req0_src_b = 1; req0_op = 4'b0010;
      req1_valid = 1; req1_src_a = 10; req1_src_b = 1; req1_op = 4'b0001;
      rsp0_ready = 1; rsp1_ready = 1;
      n = 0;
      cyc = 0;
      while (n < 6 && cyc < 60) begin
         @(negedge clk); #1;
         cyc++;
         if (req0_ready && req1_ready) begin
            checks++; errors++;
            $display("FAIL b2b_dual_ready at cycle %0d", cyc);
         end
         if (req0_ready || req1_ready) begin
            g[n] = req1_ready ? 1 : 0;
            t[n] = cyc;
            n++;
         end
      end
      checks++;
      if (n != 6) begin
         errors++; $display("FAIL b2b_timeout grants %0d want 6", n);
      end
      for (int i = 0; i < n; i++) begin
         int want;
`ifdef ALU_ARB_RR_EN
         want = i % 2;
`else
         want = 0;
`endif
         checks++;
         if (g[i] != want) begin
            errors++; $display("FAIL b2b_grant%0d got %0d want %0d", i, g[i], want);
         end
         if (i > 0) begin
            checks++;
            if (t[i] - t[i-1] != 3) begin
               errors++;
               $display("FAIL b2b_interval%0d got %0d want 3", i, t[i] - t[i-1]);
            end
         end
      end
      req0_valid = 0; req1_valid = 0;
      repeat (4) @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      req0_valid = 1; req0_src_a = 32'h11; req0_src_b = 32'h22; req0_op = 4'b0010;
      req1_valid = 1; req1_src_a = 9; req1_src_b = 4; req1_op = 4'b0001;
      rsp0_ready = 0; rsp1_ready = 0;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         errors++; $display("FAIL bp_accept got %b want 10", {req0_ready, req1_ready});
      end
      @(negedge clk); req0_valid = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         checks++;
         if (rsp0_valid !== 1'b1 || req1_ready !== 1'b0 ||
             rsp_result !== 32'h33 || alu_src_a !== 32'h11 || alu_src_b !== 32'h22) begin
            errors++;
            $display("FAIL bp_hold%0d v=%b r1rdy=%b r=%h a=%h b=%h want 1 0 33 11 22",
                     i, rsp0_valid, req1_ready, rsp_result, alu_src_a, alu_src_b);
         end
      end
      @(negedge clk); rsp0_ready = 1; #1;
      checks++;
      if ({rsp0_valid, req1_ready} !== 2'b10) begin
         errors++; $display("FAIL bp_hs got %b want 10", {rsp0_valid, req1_ready});
      end
      @(negedge clk); rsp0_ready = 0; #1;
      checks++;
      if ({busy, req1_ready} !== 2'b01) begin
         errors++; $display("FAIL bp_p1_accept got %b want 01", {busy, req1_ready});
      end
      @(negedge clk); req1_valid = 0; rsp1_ready = 1;
      @(negedge clk); #1;
      checks++;
      if (rsp1_valid !== 1'b1 || rsp_result !== 32'd5) begin
         errors++; $display("FAIL bp_p1_resp v=%b r=%h want 1 00000005", rsp1_valid, rsp_result);
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      int seen;
      @(negedge clk);
      req0_valid = 1; req0_src_a = 100; req0_src_b = 23; req0_op = 4'b0010;
      rsp0_ready = 1;
      @(negedge clk); req0_valid = 0; #1;
      rst_n = 0; #1;
      checks++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0 ||
          {alu_src_a, alu_src_b, alu_operation, rsp_result} !== '0) begin
         errors++;
         $display("FAIL rstmid_outputs ctl=%b a=%h r=%h want 0",
                  {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy},
                  alu_src_a, rsp_result);
      end
      @(negedge clk); rst_n = 1;
      seen = 0;
      repeat (4) begin
         @(negedge clk); #1;
         if (rsp0_valid || rsp1_valid || busy) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++; $display("FAIL rstmid_ghost active cycles %0d want 0", seen);
      end
      @(negedge clk);
      req0_valid = 1; req0_src_a = 40; req0_src_b = 2; req0_op = 4'b0010;
      @(negedge clk); req0_valid = 0;
      @(negedge clk); #1;
      checks++;
      if (rsp0_valid !== 1'b1 || rsp_result !== 32'd42) begin
         errors++; $display("FAIL rstmid_next v=%b r=%h want 1 0000002a", rsp0_valid, rsp_result);
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_same_cycle();
      @(negedge clk);
      req1_valid = 1; req1_src_a = 1; req1_src_b = 2; req1_op = 4'b0011;
      @(negedge clk); req1_valid = 0;
      @(negedge clk);
      rsp1_ready = 1;
      req0_valid = 1; req0_src_a = 6; req0_src_b = 6; req0_op = 4'b0010;
      #1;
      checks++;
      if ({rsp1_valid, req0_ready} !== 2'b10 || rsp_result !== 32'd3) begin
         errors++;
         $display("FAIL same_hs got %b r=%h want 10 00000003",
                  {rsp1_valid, req0_ready}, rsp_result);
      end
      @(negedge clk); rsp1_ready = 0; #1;
      checks++;
      if (req0_ready !== 1'b1) begin
         errors++; $display("FAIL same_next req0_ready %b want 1", req0_ready);
      end
      @(negedge clk); req0_valid = 0; rsp0_ready = 1;
      @(negedge clk); #1;
      checks++;
      if (rsp0_valid !== 1'b1 || rsp_result !== 32'd12) begin
         errors++; $display("FAIL same_resp v=%b r=%h want 1 0000000c", rsp0_valid, rsp_result);
      end
      @(negedge clk);
      idle_inputs();
   endtask

   // Transaction model: phase 0 idle, 1 executing, 2 awaiting response.
   task automatic test_random();
      int phase = 0;
      int owner = 0;
      logic [DW-1:0] m_res = '0;
      logic [DW-1:0] m_a = '0;
      logic clr0 = 0, clr1 = 0;
      logic w1, e0, e1;
`ifdef ALU_ARB_RR_EN
      int m_last = 1;
`endif
      do_reset();
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (clr0) req0_valid = 0;
         if (clr1) req1_valid = 0;
         clr0 = 0; clr1 = 0;
         if (!req0_valid && $urandom_range(0, 9) < 4) begin
            req0_valid = 1; req0_src_a = $urandom; req0_src_b = $urandom;
            req0_op = OW'($urandom_range(0, 4));
         end
         if (!req1_valid && $urandom_range(0, 9) < 4) begin
            req1_valid = 1; req1_src_a = $urandom; req1_src_b = $urandom;
            req1_op = OW'($urandom_range(0, 4));
         end
         rsp0_ready = 1'($urandom_range(0, 1));
         rsp1_ready = 1'($urandom_range(0, 1));
         #1;
`ifdef ALU_ARB_RR_EN
         w1 = (req0_valid && req1_valid) ? (m_last == 0) : req1_valid;
`else
         w1 = req1_valid && !req0_valid;
`endif
         e0 = (phase == 0) && req0_valid && !w1;
         e1 = (phase == 0) && req1_valid && w1;
         checks++;
         if ({req0_ready, req1_ready} !== {e0, e1}) begin
            errors++;
            $display("FAIL rnd_ready c%0d got %b want %b", c, {req0_ready, req1_ready}, {e0, e1});
         end
         checks++;
         if ({rsp0_valid, rsp1_valid} !== {phase == 2 && owner == 0, phase == 2 && owner == 1}) begin
            errors++;
            $display("FAIL rnd_rspv c%0d got %b phase %0d owner %0d",
                     c, {rsp0_valid, rsp1_valid}, phase, owner);
         end
         checks++;
         if (busy !== (phase != 0)) begin
            errors++; $display("FAIL rnd_busy c%0d got %b want %0d", c, busy, phase != 0);
         end
         if (phase == 2) begin
            checks++;
            if (rsp_result !== m_res) begin
               errors++; $display("FAIL rnd_result c%0d got %h want %h", c, rsp_result, m_res);
            end
         end
         if (phase != 0) begin
            checks++;
            if (alu_src_a !== m_a) begin
               errors++; $display("FAIL rnd_src_a c%0d got %h want %h", c, alu_src_a, m_a);
            end
         end
         if (e0 || e1) begin
            phase = 1;
            owner = e1 ? 1 : 0;
            m_a   = e1 ? req1_src_a : req0_src_a;
            m_res = e1 ? alu_fn(req1_src_a, req1_src_b, req1_op)
                       : alu_fn(req0_src_a, req0_src_b, req0_op);
`ifdef ALU_ARB_RR_EN
            m_last = owner;
`endif
            clr0 = e0; clr1 = e1;
         end else if (phase == 1) begin
            phase = 2;
         end else if (phase == 2 && (owner == 1 ? rsp1_ready : rsp0_ready)) begin
            phase = 0;
         end
      end
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      test_reset();
      test_add_port0();
      test_sub_port1();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_same_cycle();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
